// File: rtl/mips_multi_pkg.sv
// Shared encodings for the multicycle MIPS controller.
// State enum, opcode/funct constants, ALU codes and mux selects.
package mips_multi_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
`ifdef MIPS_MULTI_ADDI_EN
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
`endif
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // aluop: NONE leaves alu_control at zero in states that ignore the ALU
    localparam logic [1:0] ALUOP_NONE = 2'b00;
    localparam logic [1:0] ALUOP_ADD  = 2'b01;
    localparam logic [1:0] ALUOP_SUB  = 2'b10;
    localparam logic [1:0] ALUOP_FN   = 2'b11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multi_ctrl_aludec.sv
// ALU decoder: maps aluop and funct to the ALU operation code.
// Default build and MIPS_MULTI_ADDI_EN build share this file unchanged.
module mips_aludec
    import mips_multi_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alu_control
);

    // Select fixed op or decode funct for R-type execute
    always_comb begin
        alu_control = ALU_AND;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FN: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_multi_ctrl.sv
// Moore FSM controller for the multicycle MIPS datapath.
// Define MIPS_MULTI_ADDI_EN to add the ADDIEX/ADDIWB states for addi.
module mips_multi_ctrl
    import mips_multi_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        pc_en,
    output logic        i_or_d,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alusrc_A,
    output logic [1:0]  alusrc_B,
    output logic [2:0]  alu_control,
    output logic [1:0]  pc_src,
    output logic [3:0]  state
);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op;
    logic [5:0] funct;
    logic [1:0] aluop;
    logic       pc_write;
    logic       branch;
    logic       unused_instr;

    assign op           = instr[31:26];
    assign funct        = instr[5:0];
    assign unused_instr = ^instr[25:6];
    assign state        = state_q;
    assign pc_en        = pc_write | (branch & zero);

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next-state selection from current state and opcode
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
`ifdef MIPS_MULTI_ADDI_EN
                    OP_ADDI:      state_d = ADDIEX;
`endif
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
`ifdef MIPS_MULTI_ADDI_EN
            ADDIEX:  state_d = ADDIWB;
`endif
            default: state_d = FETCH;
        endcase
    end

    // Moore outputs; anything not named for a state stays zero
    always_comb begin
        i_or_d     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alusrc_A   = 1'b0;
        alusrc_B   = SRCB_B;
        aluop      = ALUOP_NONE;
        pc_src     = PCSRC_ALU;
        pc_write   = 1'b0;
        branch     = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                alusrc_B = SRCB_FOUR;
                aluop    = ALUOP_ADD;
            end
            DECODE: begin
                alusrc_B = SRCB_IMMSH;
                aluop    = ALUOP_ADD;
            end
`ifdef MIPS_MULTI_ADDI_EN
            MEMADR, ADDIEX: begin
`else
            MEMADR: begin
`endif
                alusrc_A = 1'b1;
                alusrc_B = SRCB_IMM;
                aluop    = ALUOP_ADD;
            end
            MEMRD: i_or_d = 1'b1;
            MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            RTYPEEX: begin
                alusrc_A = 1'b1;
                aluop    = ALUOP_FN;
            end
            RTYPEWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BEQEX: begin
                alusrc_A = 1'b1;
                aluop    = ALUOP_SUB;
                branch   = 1'b1;
                pc_src   = PCSRC_ALUOUT;
            end
`ifdef MIPS_MULTI_ADDI_EN
            ADDIWB: reg_write = 1'b1;
`endif
            JEX: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    mips_aludec u_aludec (
        .funct       (funct),
        .aluop       (aluop),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_mips_multi_ctrl.sv
// Bench for mips_multi_ctrl: directed literals, then random instructions
// checked each cycle against a per-opcode state-path model.
module tb_mips_multi_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        pc_en, i_or_d, mem_write, ir_write, reg_dst;
    logic        mem_to_reg, reg_write, alusrc_A;
    logic [1:0]  alusrc_B, pc_src;
    logic [2:0]  alu_control;
    logic [3:0]  state;

    int n_vec = 0;
    int n_err = 0;

    mips_multi_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .zero        (zero),
        .pc_en       (pc_en),
        .i_or_d      (i_or_d),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alusrc_A    (alusrc_A),
        .alusrc_B    (alusrc_B),
        .alu_control (alu_control),
        .pc_src      (pc_src),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en, i_or_d, mem_write, ir_write;
        logic       reg_dst, mem_to_reg, reg_write, src_a;
        logic [1:0] src_b;
        logic [2:0] alu;
        logic [1:0] pc_src;
    } outs_t;

    typedef int seq_t [6];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // State visited in each cycle of an instruction, zero-padded
    function automatic seq_t path(logic [5:0] op);
        case (op)
            6'b100011: return '{0, 1, 2, 3, 4, 0};
            6'b101011: return '{0, 1, 2, 5, 0, 0};
            6'b000000: return '{0, 1, 6, 7, 0, 0};
            6'b000100: return '{0, 1, 8, 0, 0, 0};
            6'b000010: return '{0, 1, 11, 0, 0, 0};
`ifdef MIPS_MULTI_ADDI_EN
            6'b001000: return '{0, 1, 9, 10, 0, 0};
`endif
            default:   return '{0, 1, 0, 0, 0, 0};
        endcase
    endfunction

    function automatic logic [2:0] fmap(logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic outs_t exp_outs(int st, logic z, logic [5:0] fn);
        outs_t o;
        o = '0;
        case (st)
            0: begin
                o.ir_write = 1; o.pc_en = 1;
                o.src_b = 2'b01; o.alu = 3'b010;
            end
            1: begin o.src_b = 2'b11; o.alu = 3'b010; end
            2, 9: begin
                o.src_a = 1; o.src_b = 2'b10; o.alu = 3'b010;
            end
            3: o.i_or_d = 1;
            4: begin o.reg_write = 1; o.mem_to_reg = 1; end
            5: begin o.i_or_d = 1; o.mem_write = 1; end
            6: begin o.src_a = 1; o.alu = fmap(fn); end
            7: begin o.reg_write = 1; o.reg_dst = 1; end
            8: begin
                o.src_a = 1; o.alu = 3'b110;
                o.pc_src = 2'b01; o.pc_en = z;
            end
            10: o.reg_write = 1;
            11: begin o.pc_en = 1; o.pc_src = 2'b10; end
            default: o = '0;
        endcase
        return o;
    endfunction

    seq_t       m_seq = '{0, 0, 0, 0, 0, 0};
    int         m_idx = 0;
    bit         m_valid = 0;
    logic [3:0] exp_st;
    outs_t      act;

    assign exp_st = (m_idx == 0) ? 4'd0 : 4'(m_seq[m_idx]);
    assign act = {pc_en, i_or_d, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, alusrc_A, alusrc_B,
                  alu_control, pc_src};

    // Model: advance along the opcode's path, restart on reset
    always @(posedge clk) begin
        if (reset) begin
            m_idx   <= 0;
            m_valid <= 1'b1;
        end else if (m_idx == 0) begin
            m_seq <= path(instr[31:26]);
            m_idx <= 1;
        end else if (m_seq[m_idx + 1] == 0) begin
            m_idx <= 0;
        end else begin
            m_idx <= m_idx + 1;
        end
    end

    // Per-cycle compare of state and all outputs
    always @(negedge clk) begin
        if (m_valid) begin
            chk("state", 32'(state), 32'(exp_st));
            chk("outs", 32'(act),
                32'(exp_outs(int'(exp_st), zero, instr[5:0])));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic es(logic [3:0] s);
        chk("dir_state", 32'(state), 32'(s));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        logic [5:0] fn;
        case ($urandom_range(0, 7))
            0:       op = 6'b100011;
            1:       op = 6'b101011;
            2:       op = 6'b000000;
            3:       op = 6'b000100;
            4:       op = 6'b000010;
            5:       op = 6'b001000;
            default: op = 6'($urandom);
        endcase
        case ($urandom_range(0, 5))
            0:       fn = 6'h20;
            1:       fn = 6'h22;
            2:       fn = 6'h24;
            3:       fn = 6'h25;
            4:       fn = 6'h2A;
            default: fn = 6'($urandom);
        endcase
        return {op, 20'($urandom), fn};
    endfunction

    initial begin
        reset = 1'b1;
        zero  = 1'b0;
        instr = 32'h8C090004;
        step(); step();
        reset = 1'b0;
        // lw
        es(0);
        chk("fetch_irw", 32'(ir_write), 32'd1);
        chk("fetch_pcen", 32'(pc_en), 32'd1);
        step(); es(1);
        step(); es(2);
        step(); es(3);
        chk("lw_iord", 32'(i_or_d), 32'd1);
        step(); es(4);
        chk("lw_rw", 32'(reg_write), 32'd1);
        chk("lw_m2r", 32'(mem_to_reg), 32'd1);
        step(); es(0);
        // sw
        instr = 32'hAC090004;
        step(); es(1);
        step(); es(2);
        step(); es(5);
        chk("sw_mw", 32'(mem_write), 32'd1);
        chk("sw_rw", 32'(reg_write), 32'd0);
        step(); es(0);
        // slt
        instr = 32'h0149402A;
        step(); es(1);
        step(); es(6);
        chk("slt_alu", 32'(alu_control), 32'd7);
        step(); es(7);
        chk("slt_dst", 32'(reg_dst), 32'd1);
        chk("slt_rw", 32'(reg_write), 32'd1);
        step(); es(0);
        // beq
        instr = 32'h11090002;
        step(); es(1);
        zero = 1'b1; #1;
        chk("dec_pcen", 32'(pc_en), 32'd0);
        step(); es(8);
        chk("beq_pcen1", 32'(pc_en), 32'd1);
        chk("beq_pcsrc", 32'(pc_src), 32'd1);
        zero = 1'b0; #1;
        chk("beq_pcen0", 32'(pc_en), 32'd0);
        step(); es(0);
        // j
        instr = 32'h08000010;
        step(); es(1);
        step(); es(11);
        chk("j_pcen", 32'(pc_en), 32'd1);
        chk("j_pcsrc", 32'(pc_src), 32'd2);
        step(); es(0);
        // unknown op
        instr = 32'hFC000000;
        step(); es(1);
        chk("unk_strb", 32'({mem_write, reg_write, ir_write, pc_en}), 32'd0);
        step(); es(0);
        // addi
        instr = 32'h20090004;
        step(); es(1);
        step();
`ifdef MIPS_MULTI_ADDI_EN
        es(9);
        chk("addi_srcb", 32'(alusrc_B), 32'd2);
        step(); es(10);
        chk("addi_rw", 32'(reg_write), 32'd1);
        step(); es(0);
`else
        es(0);
`endif
        // reset in MEMRD
        instr = 32'h8C090004;
        step(); step(); step(); es(3);
        reset = 1'b1; #1;
        chk("rst_mw", 32'(mem_write), 32'd0);
        chk("rst_rw", 32'(reg_write), 32'd0);
        step(); es(0);
        chk("rst_mw2", 32'(mem_write), 32'd0);
        chk("rst_rw2", 32'(reg_write), 32'd0);
        reset = 1'b0;
        // random traffic
        repeat (3000) begin
            reset = ($urandom_range(0, 49) == 0);
            zero  = 1'($urandom);
            if (exp_st == 4'd0) instr = rand_instr();
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
